dcache_line_fill: RTL and testbench
===================================

Name: dcache_line_fill

Overview:
Refill engine directly upstream of the dcache data RAM (four 32x8 dual-port byte banks forming 32 words). On a miss it requests an 8-word line from memory and accepts the beats critical-word-first with wrap-around. It writes each beat into all four byte banks at the matching word address, forwards the critical word to the load pipeline, and commits the tag/valid entry when the line is complete.

Parameters:
LINE_WORDS, 8, words per line; power of two; 32/LINE_WORDS lines in the RAM.
TAG_W, 25, tag width = 32 - 5 word-address bits - 2 byte bits.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
miss_valid  in  1  miss request from dcache control
miss_addr  in  32  byte address of the missing access
miss_ready  out  1  engine idle, request accepted when miss_valid & miss_ready
mem_req  out  1  memory burst request, held until mem_ack
mem_addr  out  32  burst start address = {miss_addr[31:2],2'b00} (critical word)
mem_ack  in  1  memory accepted the request (single-cycle pulse)
mem_rvalid  in  1  read beat valid
mem_rdata  in  32  read beat data
ram_waddr  out  5  word address into the byte banks
ram_wdata  out  32  bank3..bank0 = bytes [31:24]..[7:0]
ram_we  out  4  per-bank write enable (all four asserted together)
crit_valid  out  1  one-cycle pulse, critical word available
crit_data  out  32  critical word
tag_we  out  1  one-cycle tag/valid commit pulse
tag_idx  out  2  line index miss_addr[6:5]
tag_data  out  TAG_W  miss_addr[31:7]
fill_done  out  1  one-cycle pulse, same cycle as tag_we

Behaviour:
- Reset (async, reset_n=0): state IDLE; miss_ready=1; all other outputs 0, including mem_addr, ram_waddr, ram_wdata, crit_data, tag_idx and tag_data; beat counter 0. Deasserting reset mid-burst abandons the fill: no tag write, and later beats are ignored in IDLE.
- States: IDLE -> REQ -> BURST -> DONE -> IDLE.
- IDLE: miss_ready=1. On miss_valid, latch miss_addr, drive mem_req=1 and mem_addr, then go to REQ next cycle with miss_ready=0.
- REQ: hold mem_req and mem_addr stable until mem_ack. mem_ack drops mem_req next cycle and moves to BURST. A beat arriving in the same cycle as mem_ack is accepted as beat 0.
- BURST: each mem_rvalid beat k (0..7) is written combinationally-registered. Next cycle: ram_we=4'hF, ram_waddr = {idx, (woff+k) mod 8}, where woff=miss_addr[4:2]. The word offset wraps 7->0 while the index bits stay fixed.
- Write latency: one cycle from mem_rvalid to ram_we; the RAM sees at most one write per cycle. ram_we=0 in cycles without a beat; gaps of any length are allowed.
- Beat 0 also raises crit_valid for one cycle, with crit_data=beat data, in the same cycle as its RAM write.
- After beat 7 is accepted: go to DONE. In DONE, tag_we=1, fill_done=1, tag_idx and tag_data driven, for one cycle. Then IDLE, with miss_ready=1 the following cycle.
- The line is not marked valid until all 8 words are written (tag_we strictly after the last ram_we).
- miss_valid while busy: ignored; the requester holds it.
- mem_rvalid in IDLE, REQ-before-ack or DONE: ignored, with no RAM write.
- miss_addr[1:0] is ignored for fill; the critical word is word-aligned.
- Back-to-back: a new miss may be accepted in the cycle miss_ready is 1 after DONE. Minimum fill = 1 (IDLE) + 1 (REQ w/ ack) + 8 (beats) + 1 (DONE) cycles.

Test Plan:
- Aligned fill: miss_addr=0x0000_1040 (idx 2, woff 0), ack next cycle, 8 consecutive beats 0xA0..0xA7. Required: ram_waddr 16..23 in order with ram_we=4'hF; crit_data=0xA0; tag_we with tag_idx=2, tag_data=0x20.
- Wrap-around: miss_addr=0x0000_007C (idx 3, woff 7), beats D0..D7. Required: waddr sequence 31,24,25,...,30; mem_addr=0x7C; crit_valid on the first write only.
- Stalled memory: ack delayed 5 cycles, then random mem_rvalid gaps. Required: mem_req/mem_addr stable until ack, exactly 8 ram_we pulses, and tag_we one cycle after the last write.
- Busy rejection: a second miss_valid held during BURST. Required: miss_ready=0 and no second mem_req until after fill_done. The second miss is then accepted and refilled correctly.
- Reset mid-burst: assert reset_n=0 after beat 3, release, then send 4 stray beats. Required: all outputs 0 immediately, no ram_we, no tag_we, miss_ready=1.
- Spurious beats: mem_rvalid pulses in IDLE and in REQ before ack. Required: no ram_we and no crit_valid.

Source files
------------

// File: rtl/dcache_line_fill.sv
`timescale 1ns/1ps
// Line refill engine: requests a line, writes critical-word-first wrapped beats into the byte banks, commits the tag.
// Latency: mem_rvalid -> ram_we one cycle; tag_we/fill_done one cycle after the last RAM write.
// Backpressure: miss_ready low while busy (requester holds miss_valid); beats outside an active burst are dropped.
module dcache_line_fill #(
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 25
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          miss_valid,
    input  logic [31:0]                   miss_addr,
    output logic                          miss_ready,
    output logic                          mem_req,
    output logic [31:0]                   mem_addr,
    input  logic                          mem_ack,
    input  logic                          mem_rvalid,
    input  logic [31:0]                   mem_rdata,
    output logic [4:0]                    ram_waddr,
    output logic [31:0]                   ram_wdata,
    output logic [3:0]                    ram_we,
    output logic                          crit_valid,
    output logic [31:0]                   crit_data,
    output logic                          tag_we,
    output logic [4-$clog2(LINE_WORDS):0] tag_idx,
    output logic [TAG_W-1:0]              tag_data,
    output logic                          fill_done
);

    localparam int OB = $clog2(LINE_WORDS);
    localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   addr_q;
    logic [OB-1:0] cnt_q;
    logic          last_q;
    logic          accept;
    logic          beat_ok;
    logic [OB-1:0] woff;
    logic          unused_bits;

    assign unused_bits = ^miss_addr[1:0];
    assign woff        = addr_q[OB+1:2];
    assign accept      = (state == IDLE) && miss_valid;
    // A beat coinciding with mem_ack counts as beat 0; once the last beat is in, further beats are dropped.
    assign beat_ok     = mem_rvalid && !last_q &&
                         (((state == REQ) && mem_ack) || (state == BURST));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = REQ;
            REQ:     if (mem_ack) state_nxt = BURST;
            BURST:   if (last_q)  state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            ram_we     <= 4'h0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= {miss_addr[31:2], 2'b00};
            end
            if (beat_ok) begin
                cnt_q     <= cnt_q + OB'(1);
                last_q    <= (cnt_q == LAST);
                ram_waddr <= {addr_q[6:2+OB], woff + cnt_q};
                ram_wdata <= mem_rdata;
            end else if (state == DONE) begin
                last_q <= 1'b0;
            end
            ram_we     <= beat_ok ? 4'hF : 4'h0;
            crit_valid <= beat_ok && (cnt_q == '0);
            if (beat_ok && (cnt_q == '0)) begin
                crit_data <= mem_rdata;
            end
        end
    end

    // Tag commit sits one cycle behind the final RAM write, so the line never reads valid half-filled.
    assign miss_ready = (state == IDLE);
    assign mem_req    = (state == REQ);
    assign mem_addr   = addr_q;
    assign tag_we     = (state == DONE);
    assign fill_done  = (state == DONE);
    assign tag_idx    = tag_we ? addr_q[6:2+OB] : '0;
    assign tag_data   = tag_we ? addr_q[31:32-TAG_W] : '0;

endmodule

// File: tb/tb_dcache_line_fill.sv
`timescale 1ns/1ps
// Directed bench for dcache_line_fill: drives misses and memory beats, checks RAM writes, critical word and tag commit.
module tb_dcache_line_fill;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  ram_waddr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic        crit_valid;
    logic [31:0] crit_data;
    logic        tag_we;
    logic [1:0]  tag_idx;
    logic [24:0] tag_data;
    logic        fill_done;

    dcache_line_fill dut (
        .clk(clk), .reset_n(reset_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .crit_valid(crit_valid), .crit_data(crit_data),
        .tag_we(tag_we), .tag_idx(tag_idx), .tag_data(tag_data), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Write/commit recorder, sampled on the falling edge.
    int          cyc = 0;
    int          nwe = 0;
    int          ncrit = 0;
    int          ntag = 0;
    int          crit_at = 0;
    int          last_we_cyc = 0;
    int          tag_cyc = 0;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wbe[$];
    logic [31:0] crit_d;
    logic [1:0]  tidx;
    logic [24:0] tdat;
    logic        tfd;

    always @(negedge clk) begin
        cyc++;
        if (ram_we != 4'h0) begin
            nwe++;
            wa.push_back(ram_waddr);
            wd.push_back(ram_wdata);
            wbe.push_back(ram_we);
            last_we_cyc = cyc;
            if (crit_valid) crit_at = nwe;
        end
        if (crit_valid) begin
            ncrit++;
            crit_d = crit_data;
        end
        if (tag_we) begin
            ntag++;
            tag_cyc = cyc;
            tidx = tag_idx;
            tdat = tag_data;
            tfd  = fill_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic beat(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    int ew[8];
    int bw, bc, bt;

    task automatic snap();
        bw = nwe;
        bc = ncrit;
        bt = ntag;
    endtask

    // ew holds the hand-computed word-address order for the fill.
    task automatic check_fill(input string t, input logic [31:0] dbase,
                              input logic [1:0] idx, input logic [24:0] tag);
        chk({t, "_nwe"}, nwe - bw, 8);
        if (nwe - bw == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_waddr%0d", t, i), wa[bw+i], ew[i]);
                chk($sformatf("%s_wdata%0d", t, i), wd[bw+i], dbase + i);
                chk($sformatf("%s_we%0d", t, i), wbe[bw+i], 4'hF);
            end
        end
        chk({t, "_ncrit"}, ncrit - bc, 1);
        chk({t, "_crit_at"}, crit_at, bw + 1);
        chk({t, "_crit_data"}, crit_d, dbase);
        chk({t, "_ntag"}, ntag - bt, 1);
        chk({t, "_tag_idx"}, tidx, idx);
        chk({t, "_tag_data"}, tdat, tag);
        chk({t, "_tag_gap"}, tag_cyc - last_we_cyc, 1);
        chk({t, "_fill_done"}, tfd, 1'b1);
    endtask

    int gaps[8];

    initial begin
        reset_n = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        idle(2);
        chk("rst_miss_ready", miss_ready, 1'b1);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ram", {ram_we, ram_waddr, ram_wdata}, 0);
        chk("rst_crit", {crit_valid, crit_data}, 0);
        chk("rst_tag", {tag_we, fill_done, tag_idx, tag_data}, 0);
        reset_n = 1'b1;
        tick();

        // Aligned fill: idx 2, woff 0
        snap();
        miss_valid = 1'b1; miss_addr = 32'h0000_1040;
        tick();
        miss_valid = 1'b0;
        chk("t1_mem_req", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1040);
        chk("t1_busy", miss_ready, 1'b0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_req_drop", mem_req, 1'b0);
        for (int i = 0; i < 8; i++) beat(32'hA0 + i);
        idle(3);
        ew = '{16, 17, 18, 19, 20, 21, 22, 23};
        check_fill("t1", 32'hA0, 2'd2, 25'h20);
        chk("t1_idle", miss_ready, 1'b1);

        // Wrap-around: idx 3, woff 7, beat 0 arrives with the ack
        snap();
        miss_valid = 1'b1; miss_addr = 32'h0000_007C;
        tick();
        miss_valid = 1'b0;
        chk("t2_mem_addr", mem_addr, 32'h0000_007C);
        mem_ack = 1'b1;
        beat(32'hD0);
        mem_ack = 1'b0;
        for (int i = 1; i < 8; i++) beat(32'hD0 + i);
        idle(3);
        ew = '{31, 24, 25, 26, 27, 28, 29, 30};
        check_fill("t2", 32'hD0, 2'd3, 25'h0);

        // Stalled memory: ack after 5 cycles, irregular beat gaps, low address bits ignored
        snap();
        miss_valid = 1'b1; miss_addr = 32'h1234_567B;
        tick();
        miss_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_req_hold%0d", i), mem_req, 1'b1);
            chk($sformatf("t3_addr_hold%0d", i), mem_addr, 32'h1234_5678);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        gaps = '{0, 2, 1, 0, 3, 0, 1, 2};
        for (int i = 0; i < 8; i++) begin
            idle(gaps[i]);
            beat(32'h5000 + i);
        end
        idle(3);
        ew = '{30, 31, 24, 25, 26, 27, 28, 29};
        check_fill("t3", 32'h5000, 2'd3, 25'h02468AC);

        // Busy rejection: second miss held during the burst
        snap();
        miss_valid = 1'b1; miss_addr = 32'h0000_0020;
        tick();
        miss_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) beat(32'hB0 + i);
        miss_valid = 1'b1; miss_addr = 32'h0000_0044;
        for (int i = 3; i < 8; i++) begin
            chk($sformatf("t4_busy%0d", i), miss_ready, 1'b0);
            chk($sformatf("t4_noreq%0d", i), mem_req, 1'b0);
            beat(32'hB0 + i);
        end
        chk("t4_busy_lastwr", {miss_ready, mem_req}, 2'b00);
        tick();
        chk("t4_done", fill_done, 1'b1);
        chk("t4_busy_done", {miss_ready, mem_req}, 2'b00);
        tick();
        chk("t4_ready_after", miss_ready, 1'b1);
        tick();
        miss_valid = 1'b0;
        chk("t4_req2", mem_req, 1'b1);
        chk("t4_addr2", mem_addr, 32'h0000_0044);
        ew = '{8, 9, 10, 11, 12, 13, 14, 15};
        check_fill("t4a", 32'hB0, 2'd1, 25'h0);
        snap();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'hE0 + i);
        idle(3);
        ew = '{17, 18, 19, 20, 21, 22, 23, 16};
        check_fill("t4b", 32'hE0, 2'd2, 25'h0);

        // Reset mid-burst after beat 3, then stray beats
        snap();
        miss_valid = 1'b1; miss_addr = 32'h0000_1040;
        tick();
        miss_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'hC0 + i);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_miss_ready", miss_ready, 1'b1);
        chk("t5_mem", {mem_req, mem_addr}, 0);
        chk("t5_ram", {ram_we, ram_waddr, ram_wdata}, 0);
        chk("t5_crit", {crit_valid, crit_data}, 0);
        chk("t5_tag", {tag_we, fill_done, tag_idx, tag_data}, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) beat(32'h99 + i);
        idle(3);
        chk("t5_nwe", nwe - bw, 4);
        chk("t5_ntag", ntag - bt, 0);
        chk("t5_ncrit", ncrit - bc, 1);
        chk("t5_ready", miss_ready, 1'b1);

        // Spurious beats in IDLE, REQ before ack, and DONE
        snap();
        beat(32'h77);
        beat(32'h78);
        miss_valid = 1'b1; miss_addr = 32'h0000_0400;
        tick();
        miss_valid = 1'b0;
        beat(32'h66);
        beat(32'h67);
        idle(1);
        chk("t6_req_still", mem_req, 1'b1);
        chk("t6_no_we", nwe - bw, 0);
        chk("t6_no_crit", ncrit - bc, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) beat(32'hF0 + i);
        tick();
        chk("t6_in_done", tag_we, 1'b1);
        beat(32'h55);
        idle(3);
        ew = '{0, 1, 2, 3, 4, 5, 6, 7};
        check_fill("t6", 32'hF0, 2'd0, 25'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
